// File: rtl/dmem_mmio_if.sv
// Data-memory port between the CPU memory stage and the data-side memory subsystem.
// Latency: address/strobe are consumed combinationally, mem_rdata is returned one cycle later.
// Backpressure: none; the subsystem accepts one word access every cycle.
//
// Signals:
//   mem_addr   byte address from the memory stage
//   mem_wdata  store data
//   mem_write  store strobe, one word per asserted cycle
//   mem_rdata  registered read data for writeback
interface dmem_mmio_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped GPIO, cycle counter and FIFO-buffered 8N1 UART transmitter.
// Latency: reads return 1 cycle after the address (read-first on RAM and I/O registers).
// Backpressure: none on the bus; UART pushes into a full FIFO are dropped and flag overflow.
//
// Ports:
//   clk       system clock, all state on posedge
//   reset     asynchronous, active-high
//   bus       slave side of dmem_mmio_if (mem_addr, mem_wdata, mem_write, mem_rdata)
//   gpio_out  GPIO output register
//   uart_tx   serial TX line, idle high, driven from a flop
//
// I/O map (mem_addr[31]=1, decoded on mem_addr[3:2]):
//   0x0 GPIO   0x4 UART data/status   0x8 CYCLE counter   0xC reserved (reads 0)
module dmem_mmio #(
    parameter int RAM_AW  = 10,
    parameter int CLK_DIV = 868,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus,
    output logic [7:0]  gpio_out,
    output logic        uart_tx
);

    localparam int                TW       = $clog2(CLK_DIV);
    localparam logic [TW-1:0]     BIT_LAST = TW'(CLK_DIV - 1);
    localparam int                DEPTH    = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              io_sel;
    logic [1:0]        io_reg;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_wr;
    logic              gpio_wr;
    logic              uart_push;
    logic              uart_rd;
    logic              cyc_wr;

    assign io_sel    = bus.mem_addr[31];
    assign io_reg    = bus.mem_addr[3:2];
    assign ram_idx   = bus.mem_addr[RAM_AW+1:2];
    assign ram_wr    = bus.mem_write && !io_sel;
    assign gpio_wr   = bus.mem_write && io_sel && (io_reg == 2'd0);
    assign uart_push = bus.mem_write && io_sel && (io_reg == 2'd1);
    assign cyc_wr    = bus.mem_write && io_sel && (io_reg == 2'd2);
    // Any cycle that addresses UART status counts as a status read.
    assign uart_rd   = io_sel && (io_reg == 2'd1);

    // Bits above the RAM index alias, byte-lane bits are meaningless for word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[30:RAM_AW+2], bus.mem_addr[1:0]};

    // ------------------------------------------------------------------
    // Data RAM (not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_idx] <= bus.mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // GPIO and cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (gpio_wr) begin
                gpio_out <= bus.mem_wdata[7:0];
            end
            cycle_cnt <= cyc_wr ? 32'd0 : cycle_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // UART TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             ovf;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    always_ff @(posedge clk) begin
        if (uart_push && !fifo_full) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            // Full is judged before any same-cycle pop, so a push into a full
            // FIFO is lost even if the transmitter frees a slot on this edge.
            if (uart_push && !fifo_full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (uart_push && fifo_full) begin
                ovf <= 1'b1;
            end else if (uart_rd) begin
                ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t     state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          tx_d;
    logic          tx_busy;

    assign tx_busy = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            uart_tx <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so the registered
    // uart_tx lines up with the registered state.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        tx_d      = 1'b1;
        fifo_pop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
                    timer_d  = BIT_LAST;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (timer == '0) begin
                    timer_d   = BIT_LAST;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = shift[0];
                end else begin
                    timer_d = timer - 1'b1;
                    tx_d    = 1'b0;
                end
            end
            S_DATA: begin
                if (timer == '0) begin
                    timer_d = BIT_LAST;
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift >> 1;
                        bit_idx_d = bit_idx + 3'd1;
                        tx_d      = shift[1];
                    end
                end else begin
                    timer_d = timer - 1'b1;
                    tx_d    = shift[0];
                end
            end
            S_STOP: begin
                if (timer == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path: combinational select, registered data
    // ------------------------------------------------------------------
    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        if (!io_sel) begin
            rd_next = ram[ram_idx];
        end else begin
            case (io_reg)
                2'd0:    rd_next = {24'b0, gpio_out};
                2'd1:    rd_next = {29'b0, ovf, fifo_full, tx_busy};
                2'd2:    rd_next = cycle_cnt;
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: randomized bus traffic against a behavioural model,
// read data checked by a scoreboard monitor, UART line decoded by a receiver.
// Runs with small parameters so UART frames are short.
module tb_dmem_mmio;
    localparam int RAM_AW  = 6;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_UART = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_RSV  = 32'h8000_000C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] gpio_out;
    logic       uart_tx;

    dmem_mmio_if bus ();

    dmem_mmio #(
        .RAM_AW  (RAM_AW),
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t            rd_q[$];
    logic [7:0]      tx_q[$];
    logic [31:0]     m_ram[int];
    logic [7:0]      m_gpio = 8'h00;
    int unsigned     tb_cyc = 0;
    int unsigned     cyc_base = 0;
    int              frames_rx = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // One bus cycle: drive at negedge, push what mem_rdata must show after the next posedge.
    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                          input string name, input bit use_exp = 1'b0,
                          input logic [31:0] exp_val = 32'h0);
        exp_t e;
        int   idx;
        @(negedge clk);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_write = wr;
        e.chk  = 1'b0;
        e.val  = '0;
        e.name = name;
        if (!addr[31]) begin
            idx = int'(addr[RAM_AW+1:2]);
            if (m_ram.exists(idx)) begin
                e.chk = 1'b1;
                e.val = m_ram[idx];
            end
            if (wr) m_ram[idx] = wdata;
        end else begin
            case (addr[3:2])
                2'd0: begin
                    e.chk = 1'b1;
                    e.val = {24'b0, m_gpio};
                    if (wr) m_gpio = wdata[7:0];
                end
                2'd1: e.chk = 1'b0;
                2'd2: begin
                    e.chk = 1'b1;
                    e.val = tb_cyc - cyc_base;
                    if (wr) cyc_base = tb_cyc + 1;
                end
                default: begin
                    e.chk = 1'b1;
                    e.val = 32'h0;
                end
            endcase
        end
        if (use_exp) begin
            e.chk = 1'b1;
            e.val = exp_val;
        end
        rd_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(A_RSV, 32'h0, 1'b0, "idle_rd");
    endtask

    // ---------------- read-data monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (e.chk) check(e.name, bus.mem_rdata, e.val);
            end
        end
    end

    // ---------------- UART receiver ----------------
    initial begin : rx
        logic [9:0] bits;
        bit         bad;
        bit         aborted;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                bits    = '0;
                bad     = 1'b0;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int k = 0; k < CLK_DIV && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (reset) aborted = 1'b1;
                        else if (k == 0) bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) bad = 1'b1;
                    end
                end
                if (!aborted) begin
                    frames_rx++;
                    check("frame_shape", {29'b0, bad, bits[0], bits[9]}, 32'h1);
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_extra got=%h expected=no frame", bits[8:1]);
                    end else begin
                        exp_b = tx_q.pop_front();
                        check("frame_byte", {24'b0, bits[8:1]}, {24'b0, exp_b});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] a;
        logic [7:0]  b;
        int          frames_before;
        int          budget;

        bus.mem_addr  = A_RSV;
        bus.mem_wdata = 32'h0;
        bus.mem_write = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_gpio", {24'b0, gpio_out}, 32'h0);
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        cyc_base = tb_cyc;

        // RAM write, readback, alias
        bus_op(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, "ram_wr");
        bus_op(32'h0000_0040, 32'h0, 1'b0, "ram_rd", 1'b1, 32'hDEAD_BEEF);
        bus_op(32'h0000_0040 + (32'd4 << RAM_AW), 32'h0, 1'b0, "ram_alias", 1'b1, 32'hDEAD_BEEF);

        // read-first
        bus_op(32'h0000_0010, 32'h5, 1'b1, "rf_pre");
        bus_op(32'h0000_0010, 32'h1, 1'b1, "rf_old", 1'b1, 32'h5);
        bus_op(32'h0000_0010, 32'h0, 1'b0, "rf_new", 1'b1, 32'h1);

        // GPIO
        bus_op(A_GPIO, 32'h1234_56A5, 1'b1, "gpio_wr", 1'b1, 32'h0);
        idle(1);
        check("gpio_out", {24'b0, gpio_out}, 32'hA5);
        bus_op(A_GPIO, 32'h0, 1'b0, "gpio_rd", 1'b1, 32'hA5);

        // cycle counter clear and wrap
        bus_op(A_CYC, 32'h0, 1'b1, "cyc_clr");
        idle(2);
        bus_op(A_CYC, 32'h0, 1'b0, "cyc_after_clr", 1'b1, 32'd2);
        @(posedge clk);
        #1;
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cyc_base = tb_cyc + 1;
        bus_op(A_CYC, 32'h0, 1'b0, "cyc_max", 1'b1, 32'hFFFF_FFFF);
        bus_op(A_CYC, 32'h0, 1'b0, "cyc_wrap", 1'b1, 32'h0);

        // randomized RAM / GPIO / CYCLE / reserved traffic
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = int'($urandom_range(0, 99));
            a = $urandom();
            if (kind < 60) begin
                a[31] = 1'b0;
                a[RAM_AW+1:2] = RAM_AW'($urandom_range(0, 15));
                bus_op(a, $urandom(), 1'($urandom_range(0, 1)), "rand_ram");
            end else if (kind < 75) begin
                bus_op(A_GPIO | (a & 32'h3), $urandom(), 1'($urandom_range(0, 1)), "rand_gpio");
            end else if (kind < 90) begin
                bus_op(A_CYC, 32'h0, ($urandom_range(0, 9) == 0), "rand_cyc");
            end else begin
                bus_op(A_RSV, $urandom(), 1'($urandom_range(0, 1)), "rand_rsv");
            end
        end
        idle(1);

        // single UART frame
        tx_q.push_back(8'h55);
        bus_op(A_UART, 32'h55, 1'b1, "uart_push_st", 1'b1, 32'h0);
        idle(3);
        bus_op(A_UART, 32'h0, 1'b0, "uart_busy", 1'b1, 32'h1);
        idle(44);
        bus_op(A_UART, 32'h0, 1'b0, "uart_done", 1'b1, 32'h0);
        check("frame_55_seen", tx_q.size(), 32'h0);

        // overflow: 6 back-to-back pushes, 5 survive
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom());
            if (i < 5) tx_q.push_back(b);
            bus_op(A_UART, {24'h0, b}, 1'b1, "ovf_push");
        end
        bus_op(A_UART, 32'h0, 1'b0, "ovf_status", 1'b1, 32'h7);
        bus_op(A_UART, 32'h0, 1'b0, "ovf_cleared", 1'b1, 32'h3);
        budget = 0;
        while (tx_q.size() != 0 && budget < 400) begin
            idle(1);
            budget++;
        end
        idle(3);
        check("ovf_frames_left", tx_q.size(), 32'h0);
        bus_op(A_UART, 32'h0, 1'b0, "ovf_idle", 1'b1, 32'h0);

        // async reset in the middle of a DATA bit
        bus_op(A_GPIO, 32'hA5, 1'b1, "gpio_rewr");
        tx_q.push_back(8'h3C);
        bus_op(A_UART, 32'h3C, 1'b1, "rst_push");
        for (int i = 0; i < 7; i++) bus_op(A_GPIO, 32'h0, 1'b0, "rst_gpio_rd", 1'b1, 32'hA5);
        @(posedge clk);
        #3;
        check("pre_rst_tx", {31'b0, uart_tx}, 32'h0);
        check("pre_rst_rdata", bus.mem_rdata, 32'hA5);
        frames_before = frames_rx;
        reset = 1'b1;
        #1;
        check("async_rst_tx", {31'b0, uart_tx}, 32'h1);
        check("async_rst_rdata", bus.mem_rdata, 32'h0);
        tx_q.delete();
        bus.mem_addr  = A_RSV;
        bus.mem_write = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        m_gpio   = 8'h00;
        cyc_base = tb_cyc;
        bus_op(A_UART, 32'h0, 1'b0, "post_rst_status", 1'b1, 32'h0);
        idle(60);
        check("post_rst_frames", frames_rx, frames_before);
        check("post_rst_tx", {31'b0, uart_tx}, 32'h1);
        check("post_rst_gpio", {24'b0, gpio_out}, 32'h0);
        bus_op(A_CYC, 32'h0, 1'b0, "post_rst_cyc");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
